// File: rtl/stage1_addr_gen.sv
// Stage 1 address/control generator: loads a 512-sample frame into four SRAM
// banks, then reads it back in 32x4 transposed order for the radix-4 MDC core.
module stage1_addr_gen #(
  parameter int unsigned AddrWidth = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  output logic                      start_fft_o,
  output logic [3:0]                wen_o,
  output logic [3:0][AddrWidth-1:0] addr_gen_o,
  output logic                      stage1,
  output logic                      done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [AddrWidth-1:0] CntLast = '1;

  state_e               state_q;
  logic [AddrWidth-1:0] cnt_q;
  logic                 start_fft_q;
  logic                 done_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      start_fft_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // SRAM read latency is one cycle: the first read word appears the
      // cycle after READ issues address 0; done lands in the FLUSH cycle.
      start_fft_q <= (state_q == READ) && (cnt_q == '0);
      done_q      <= (state_q == READ) && (cnt_q == CntLast);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_i) state_q <= WRITE;
        end
        WRITE: begin
          if (cnt_q == CntLast) begin
            state_q <= READ;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AddrWidth'(1);
          end
        end
        READ: begin
          if (cnt_q == CntLast) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AddrWidth'(1);
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    wen_o      = 4'h0;
    addr_gen_o = '0;
    stage1     = (state_q != IDLE);
    case (state_q)
      WRITE: begin
        wen_o = 4'hF;
        for (int b = 0; b < 4; b++) addr_gen_o[b] = cnt_q;
      end
      READ: begin
        for (int b = 0; b < 4; b++)
          addr_gen_o[b] = {cnt_q[1:0], cnt_q[AddrWidth-1:2]};
      end
      default: ;
    endcase
  end

  assign start_fft_o = start_fft_q;
  assign done_o      = done_q;

endmodule

// File: doc/stage1_addr_gen.md
# stage1_addr_gen

Address and control generator for stage 1 of the 2D FFT datapath. On a start pulse it first loads one 512-sample complex frame into the four-bank SRAM system, at 4 samples per cycle over 128 cycles. It then reads the frame back in stride-permuted order and pulses `start_fft_o` so the radix-4 MDC core starts on the first valid SRAM output word. It sits directly upstream of the SRAM system and R4MDC. While `stage1` is high, the top-level stage mux routes its `wen_o`/`addr_gen_o` to the SRAMs.

## Interface
- `AddrWidth`, 7, address width of each SRAM bank (bank depth 2^AddrWidth = 128)
- `clk_i` input 1: the single clock
- `rst_ni` input 1: asynchronous reset, active-low
- `start_i` input 1: frame start pulse; sampled only in IDLE
- `start_fft_o` output 1: one-cycle pulse aligned with the first valid read word at the SRAM outputs
- `wen_o` output 4: per-bank write enable, active-high, one bit per bank/lane
- `addr_gen_o` output 4×AddrWidth: per-bank address, `[b]` drives bank b
- `stage1` output 1: high while this block owns the SRAM ports
- `done_o` output 1: one-cycle pulse on return to IDLE

## Operation
- States: IDLE, WRITE, READ, FLUSH. A 7-bit counter `cnt` is cleared on every state entry.
- IDLE
  - Outputs: `wen_o=0`, all addresses 0, `stage1=0`.
  - `start_i=1` → WRITE.
- WRITE (128 cycles)
  - Outputs: `wen_o=4'hF`, `addr_gen_o[b]=cnt` for all b, `stage1=1`.
  - Lane b of input cycle k is written to bank b at address k, i.e. sample index 4k+b.
  - At `cnt=127` → READ.
- READ (128 cycles)
  - Outputs: `wen_o=0`, `stage1=1`, and `addr_gen_o[b] = {cnt[1:0], cnt[6:2]}` for all b. This stride permutation is the 32×4 transpose.
  - At `cnt=127` → FLUSH.
- FLUSH (1 cycle)
  - Outputs: `wen_o=0`, addresses 0, `stage1=1`. This keeps the stage mux on stage 1 while the last read word leaves the SRAM.
  - Next state is IDLE; `done_o` pulses in this cycle.
- `start_fft_o` is a register set in the cycle after READ with `cnt=0`, i.e. SRAM read latency is 1. It is high for exactly one cycle per frame.
- `start_i` is ignored in WRITE, READ and FLUSH; no queuing, no restart.
- `addr_gen_o` and `wen_o` are decoded combinationally from the registered state and `cnt`. They carry no glitch-sensitive logic beyond that decode.
- The counter wraps naturally at 127→0 only on a state transition. It never wraps inside a state.

## Timing
- Reset (asynchronous, any state) forces:
  - state to IDLE and `cnt` to 0
  - `start_fft_o=0`, `done_o=0`, `wen_o=0`, `addr_gen_o=0`, `stage1=0`
- Reset mid-frame abandons the frame and does not pulse `done_o`. Recovery needs a new `start_i`.
- Frame timeline, with `start_i` sampled at edge E0 (cycles numbered after E0):
  - cycles 1–128: WRITE
  - cycles 129–256: READ
  - cycle 130: `start_fft_o`
  - cycle 257: FLUSH, `done_o`
  - cycle 258: IDLE
- `stage1` is high for exactly 257 cycles per frame.
- Earliest next accepted `start_i` is in cycle 258, which gives back-to-back frames every 258 cycles.
- `start_i` held high continuously retriggers in each IDLE cycle it is seen.

## Test plan
- Reset check: assert `rst_ni=0` mid-READ (cycle 200) → all outputs 0 in the same cycle. After release, stays IDLE with no `start_fft_o` until `start_i`.
- Single frame write phase: pulse `start_i` → `wen_o=4'hF` for exactly 128 cycles, addresses 0..127 identical across banks.
- Single frame read phase:
  - read cnt=1 → address 32; cnt=4 → address 1; cnt=127 → address 127; all `wen_o=0`.
  - `start_fft_o` high only in cycle 130.
- End of frame: `done_o` pulses in cycle 257 and `stage1` falls in cycle 258. End-to-end check: a bench SRAM model loaded with index data reads back the stride-permuted sequence.
- Busy start: extra `start_i` pulses in cycles 5, 150 and 257 → no effect on timeline, exactly one frame.
- Continuous `start_i=1`: second WRITE begins cycle 259 after the first start, and `start_fft_o` pulses every 258 cycles.
